uart_frame_counter: RTL and testbench
=====================================

# uart_frame_counter

Parametrised frame-sequencing counter for the UART TX/RX paths. It replaces the fixed single-count bit counter. It counts oversampled baud ticks within each bit and bit positions within a frame, using a runtime-selectable data length, optional parity and 1 or 2 stop bits. It emits per-bit sample and end strobes, the current frame phase and a frame-done pulse, which the UART shifters and control FSMs consume.

## Interface
- OVERSAMPLE, 16: baud ticks per bit. Even, ≥4.
- MAX_DATA_BITS, 9: largest supported data length. Range 5..9.
- CNT_W, $clog2(OVERSAMPLE): sample counter width (derived, do not override).
- clk_i  in  1  clock; all logic on posedge.
- rst_ni  in  1  reset; synchronous, active-low.
- tick_i  in  1  oversample baud tick, one-cycle strobe.
- start_i  in  1  begin a frame; honoured only when idle.
- abort_i  in  1  synchronous clear to idle; highest priority after reset.
- cfg_data_bits_i  in  4  data length; sampled on accepted start.
- cfg_parity_en_i  in  1  insert parity bit; sampled on accepted start.
- cfg_stop2_i  in  1  two stop bits when 1; sampled on accepted start.
- busy_o  out  1  frame in progress.
- phase_o  out  3  uart_pkg::phase_e: IDLE, START, DATA, PARITY, STOP.
- bit_idx_o  out  4  data bit index in DATA; stop index 0/1 in STOP; 0 otherwise.
- sample_o  out  1  mid-bit strobe.
- bit_end_o  out  1  last-tick-of-bit strobe.
- frame_done_o  out  1  one-cycle pulse after the final stop bit.

## Operation
- All outputs are registered. Reset value: busy_o=0, phase_o=IDLE, bit_idx_o=0, sample_o=0, bit_end_o=0, frame_done_o=0. The sample counter and latched config are also cleared (config data length to 8).
- Accepted start (IDLE & start_i & !abort_i):
  - Latch config.
  - Set phase START, sample counter 0, bit_idx 0, busy_o=1.
- Data-length clamp at latch: a value below 5 becomes 5; a value above MAX_DATA_BITS becomes MAX_DATA_BITS.
- Ticks outside IDLE:
  - Each tick_i increments the sample counter, wrapping at OVERSAMPLE-1.
  - A tick taking the count to OVERSAMPLE/2-1 asserts sample_o.
  - A tick at count OVERSAMPLE-1 asserts bit_end_o, wraps the counter to 0 and advances the bit sequence.
- Bit sequence, advanced on each bit end:
  - START goes to DATA with idx 0.
  - In DATA, idx increments. At idx=N-1, go to PARITY if parity is enabled, else STOP idx 0.
  - PARITY goes to STOP idx 0.
  - STOP idx 0 goes to STOP idx 1 if stop2, else to IDLE.
  - STOP idx 1 goes to IDLE.
- Entering IDLE from STOP pulses frame_done_o and drops busy_o in the same cycle.
- Frame length in ticks: OVERSAMPLE × (1 + N + P + S).
- start_i while busy is ignored. Config input changes while busy have no effect.
- abort_i forces IDLE next cycle: counters cleared, busy_o=0, all strobes 0, no frame_done_o.
- start_i and abort_i in the same cycle: abort wins and the start is dropped.
- tick_i in the same cycle as an accepted start is ignored; the first counted tick is the next one.
- tick_i in IDLE has no effect.

## Timing
- Strobes (sample_o, bit_end_o, frame_done_o) go high exactly one cycle after the causing tick_i and stay high for one cycle.
- phase_o and bit_idx_o update in the same cycle as bit_end_o. bit_end_o is asserted alongside the new phase; consumers use bit_end_o as "previous bit finished".
- busy_o rises one cycle after the accepted start_i.
- Back-to-back frames: start_i in the frame_done_o cycle is accepted, because the block is idle in that cycle. There is no dead cycle beyond this.
- Reset mid-frame behaves like abort but also restores reset values of the latched config.

## Structure
- uart_pkg holds:
  - phase_e enum (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4).
  - MIN_DATA_BITS=5.
  - Default config constants shared with the TX/RX FSMs.
- One sub-module, uart_tick_counter. It is parametrised on OVERSAMPLE, with inputs clear and tick and outputs mid and wrap, and is reused by the RX start-bit detector.
- The top level holds the phase FSM, the bit index and the config latch.

## Test plan
- OVERSAMPLE=16, 8N1, tick every cycle, start at t0:
  - sample_o at ticks 7, 23, …
  - bit_end_o ×10.
  - frame_done_o exactly one cycle after the 160th tick.
  - bit_idx_o sequence 0..7 during DATA.
- 9-bit, parity, 2 stop bits (MAX_DATA_BITS=9):
  - Phases START, DATA×9, PARITY, STOP0, STOP1.
  - Frame = 208 ticks.
- cfg_data_bits_i=3, then 12: frames run 5 data bits, then 9 data bits; config changes mid-frame are ignored.
- abort_i at tick 50 of an 8N1 frame: next cycle IDLE, busy_o=0, no frame_done_o; a new start runs a full 160-tick frame.
- Contention cases:
  - start_i and abort_i together: no frame.
  - start_i with tick_i: first counted tick is the next one.
  - start_i while busy: ignored.
  - start_i in the frame_done_o cycle: back-to-back frame starts.
- rst_ni low for one cycle mid-frame: all outputs at reset values next cycle; ticks in IDLE produce no strobes.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types, limits and default frame configuration.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } phase_e;

    localparam int   MIN_DATA_BITS     = 5;
    localparam int   DEFAULT_DATA_BITS = 8;
    localparam logic DEFAULT_PARITY_EN = 1'b0;
    localparam logic DEFAULT_STOP2     = 1'b0;

    // Clamp a requested data length into MIN_DATA_BITS..max_bits.
    function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits,
                                                   input logic [3:0] max_bits);
        if (bits < 4'(MIN_DATA_BITS)) begin
            return 4'(MIN_DATA_BITS);
        end else if (bits > max_bits) begin
            return max_bits;
        end
        return bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tick_counter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tick_counter
// Description : Oversample tick counter with mid-bit and end-of-bit strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tick_counter #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic tick_i,
    output logic mid_o,
    output logic wrap_o
);

    localparam logic [CNT_W-1:0] c_last    = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] c_pre_mid = CNT_W'(OVERSAMPLE / 2 - 2);

    logic [CNT_W-1:0] r_cnt;

    // mid fires on the tick that moves the count onto the mid-bit value.
    assign mid_o  = tick_i & (r_cnt == c_pre_mid);
    assign wrap_o = tick_i & (r_cnt == c_last);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_cnt <= '0;
        end else if (tick_i) begin
            r_cnt <= wrap_o ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_frame_counter.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_counter
// Description : UART frame sequencer: bit phase, bit index and tick strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_counter
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE    = 16,
    parameter int MAX_DATA_BITS = 9,
    parameter int CNT_W         = $clog2(OVERSAMPLE)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [3:0] cfg_data_bits_i,
    input  logic       cfg_parity_en_i,
    input  logic       cfg_stop2_i,
    output logic       busy_o,
    output logic [2:0] phase_o,
    output logic [3:0] bit_idx_o,
    output logic       sample_o,
    output logic       bit_end_o,
    output logic       frame_done_o
);

    phase_e     r_phase,      w_phase_nxt;
    logic [3:0] r_bit_idx,    w_bit_idx_nxt;
    logic       r_busy,       w_busy_nxt;
    logic       r_sample,     w_sample_nxt;
    logic       r_bit_end,    w_bit_end_nxt;
    logic       r_frame_done, w_frame_done_nxt;
    logic [3:0] r_cfg_bits,   w_cfg_bits_nxt;
    logic       r_cfg_par,    w_cfg_par_nxt;
    logic       r_cfg_stop2,  w_cfg_stop2_nxt;

    logic w_cnt_clear;
    logic w_cnt_tick;
    logic w_mid;
    logic w_wrap;

    // Counter is held at zero while idle so a new frame always starts aligned.
    assign w_cnt_clear = abort_i | (r_phase == IDLE);
    assign w_cnt_tick  = tick_i & (r_phase != IDLE);

    uart_tick_counter #(
        .OVERSAMPLE (OVERSAMPLE),
        .CNT_W      (CNT_W)
    ) u_tick_counter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (w_cnt_clear),
        .tick_i  (w_cnt_tick),
        .mid_o   (w_mid),
        .wrap_o  (w_wrap)
    );

    always_comb begin
        w_phase_nxt      = r_phase;
        w_bit_idx_nxt    = r_bit_idx;
        w_busy_nxt       = r_busy;
        w_sample_nxt     = 1'b0;
        w_bit_end_nxt    = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_cfg_bits_nxt   = r_cfg_bits;
        w_cfg_par_nxt    = r_cfg_par;
        w_cfg_stop2_nxt  = r_cfg_stop2;

        if (abort_i) begin
            w_phase_nxt   = IDLE;
            w_bit_idx_nxt = 4'd0;
            w_busy_nxt    = 1'b0;
        end else if (r_phase == IDLE) begin
            if (start_i) begin
                w_cfg_bits_nxt  = clamp_data_bits(cfg_data_bits_i, 4'(MAX_DATA_BITS));
                w_cfg_par_nxt   = cfg_parity_en_i;
                w_cfg_stop2_nxt = cfg_stop2_i;
                w_phase_nxt     = START;
                w_bit_idx_nxt   = 4'd0;
                w_busy_nxt      = 1'b1;
            end
        end else begin
            w_sample_nxt  = w_mid;
            w_bit_end_nxt = w_wrap;
            if (w_wrap) begin
                case (r_phase)
                    START: begin
                        w_phase_nxt   = DATA;
                        w_bit_idx_nxt = 4'd0;
                    end
                    DATA: begin
                        if (r_bit_idx == r_cfg_bits - 4'd1) begin
                            w_phase_nxt   = r_cfg_par ? PARITY : STOP;
                            w_bit_idx_nxt = 4'd0;
                        end else begin
                            w_bit_idx_nxt = r_bit_idx + 4'd1;
                        end
                    end
                    PARITY: begin
                        w_phase_nxt   = STOP;
                        w_bit_idx_nxt = 4'd0;
                    end
                    STOP: begin
                        if (r_bit_idx == 4'd0 && r_cfg_stop2) begin
                            w_bit_idx_nxt = 4'd1;
                        end else begin
                            w_phase_nxt      = IDLE;
                            w_bit_idx_nxt    = 4'd0;
                            w_busy_nxt       = 1'b0;
                            w_frame_done_nxt = 1'b1;
                        end
                    end
                    default: begin
                        w_phase_nxt   = IDLE;
                        w_bit_idx_nxt = 4'd0;
                        w_busy_nxt    = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_phase      <= IDLE;
            r_bit_idx    <= 4'd0;
            r_busy       <= 1'b0;
            r_sample     <= 1'b0;
            r_bit_end    <= 1'b0;
            r_frame_done <= 1'b0;
            r_cfg_bits   <= 4'(DEFAULT_DATA_BITS);
            r_cfg_par    <= DEFAULT_PARITY_EN;
            r_cfg_stop2  <= DEFAULT_STOP2;
        end else begin
            r_phase      <= w_phase_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_busy       <= w_busy_nxt;
            r_sample     <= w_sample_nxt;
            r_bit_end    <= w_bit_end_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_cfg_bits   <= w_cfg_bits_nxt;
            r_cfg_par    <= w_cfg_par_nxt;
            r_cfg_stop2  <= w_cfg_stop2_nxt;
        end
    end

    assign busy_o       = r_busy;
    assign phase_o      = r_phase;
    assign bit_idx_o    = r_bit_idx;
    assign sample_o     = r_sample;
    assign bit_end_o    = r_bit_end;
    assign frame_done_o = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_counter
// Description : Directed self-checking bench for uart_frame_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_counter;

    localparam int c_os = 16;
    localparam logic [2:0] c_ph_idle   = 3'd0;
    localparam logic [2:0] c_ph_start  = 3'd1;
    localparam logic [2:0] c_ph_data   = 3'd2;
    localparam logic [2:0] c_ph_parity = 3'd3;
    localparam logic [2:0] c_ph_stop   = 3'd4;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       tick_i;
    logic       start_i;
    logic       abort_i;
    logic [3:0] cfg_data_bits_i;
    logic       cfg_parity_en_i;
    logic       cfg_stop2_i;
    logic       busy_o;
    logic [2:0] phase_o;
    logic [3:0] bit_idx_o;
    logic       sample_o;
    logic       bit_end_o;
    logic       frame_done_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_frame_counter #(
        .OVERSAMPLE    (c_os),
        .MAX_DATA_BITS (9)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .tick_i          (tick_i),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .cfg_data_bits_i (cfg_data_bits_i),
        .cfg_parity_en_i (cfg_parity_en_i),
        .cfg_stop2_i     (cfg_stop2_i),
        .busy_o          (busy_o),
        .phase_o         (phase_o),
        .bit_idx_o       (bit_idx_o),
        .sample_o        (sample_o),
        .bit_end_o       (bit_end_o),
        .frame_done_o    (frame_done_o)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"},    32'(busy_o),       0);
        chk({tag, "_phase"},   32'(phase_o),      32'(c_ph_idle));
        chk({tag, "_idx"},     32'(bit_idx_o),    0);
        chk({tag, "_sample"},  32'(sample_o),     0);
        chk({tag, "_bit_end"}, 32'(bit_end_o),    0);
        chk({tag, "_done"},    32'(frame_done_o), 0);
    endtask

    task automatic idle_ticks(input string tag, input int n);
        int activity = 0;
        tick_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            if (busy_o || sample_o || bit_end_o || frame_done_o) activity++;
        end
        tick_i = 1'b0;
        chk({tag, "_activity"}, 32'(activity), 0);
    endtask

    // Start with tick_i high on the same edge: that tick must not be counted.
    task automatic do_start(input string tag, input int bits, input logic par, input logic s2);
        cfg_data_bits_i = 4'(bits);
        cfg_parity_en_i = par;
        cfg_stop2_i     = s2;
        start_i         = 1'b1;
        tick_i          = 1'b1;
        step();
        start_i = 1'b0;
        chk({tag, "_start_busy"},  32'(busy_o),  1);
        chk({tag, "_start_phase"}, 32'(phase_o), 32'(c_ph_start));
    endtask

    task automatic run_frame(input string tag, input int cfg_bits, input int n_data,
                             input logic par, input logic s2, input int exp_ticks,
                             input int chg_at);
        logic [2:0] exp_ph[$];
        int         exp_ix[$];
        int k = 0, be = 0, done_at = -1, samp_bad = 0, busy_bad = 0;
        for (int b = 0; b < n_data; b++) begin
            exp_ph.push_back(c_ph_data);
            exp_ix.push_back(b);
        end
        if (par) begin
            exp_ph.push_back(c_ph_parity);
            exp_ix.push_back(0);
        end
        exp_ph.push_back(c_ph_stop);
        exp_ix.push_back(0);
        if (s2) begin
            exp_ph.push_back(c_ph_stop);
            exp_ix.push_back(1);
        end
        exp_ph.push_back(c_ph_idle);
        exp_ix.push_back(0);

        do_start(tag, cfg_bits, par, s2);
        while (done_at < 0 && k < exp_ticks + 32) begin
            tick_i  = 1'b1;
            start_i = (k == chg_at);
            if (k == chg_at) begin
                cfg_data_bits_i = cfg_data_bits_i ^ 4'hF;
                cfg_parity_en_i = ~cfg_parity_en_i;
                cfg_stop2_i     = ~cfg_stop2_i;
            end
            step();
            start_i = 1'b0;
            k++;
            if (sample_o !== ((k % c_os) == c_os / 2 - 1)) samp_bad++;
            if (bit_end_o) begin
                if ((k % c_os) != 0) samp_bad++;
                if (be < exp_ph.size()) begin
                    chk($sformatf("%s_ph%0d", tag, be),  32'(phase_o),   32'(exp_ph[be]));
                    chk($sformatf("%s_idx%0d", tag, be), 32'(bit_idx_o), 32'(exp_ix[be]));
                end
                be++;
            end
            if (frame_done_o) begin
                done_at = k;
                chk({tag, "_done_busy"}, 32'(busy_o), 0);
            end else if (busy_o !== 1'b1) begin
                busy_bad++;
            end
        end
        tick_i = 1'b0;
        chk({tag, "_done_tick"}, 32'(done_at),  32'(exp_ticks));
        chk({tag, "_bit_ends"},  32'(be),       32'(exp_ph.size()));
        chk({tag, "_strobes"},   32'(samp_bad), 0);
        chk({tag, "_busy"},      32'(busy_bad), 0);
    endtask

    initial begin
        rst_ni          = 1'b0;
        tick_i          = 1'b0;
        start_i         = 1'b0;
        abort_i         = 1'b0;
        cfg_data_bits_i = 4'd8;
        cfg_parity_en_i = 1'b0;
        cfg_stop2_i     = 1'b0;
        step();
        step();
        check_idle("reset");
        rst_ni = 1'b1;
        idle_ticks("idle0", 20);

        // Consecutive frames: each start lands in the previous frame_done cycle.
        run_frame("f8n1",  8, 8, 1'b0, 1'b0, 160, 70);
        run_frame("f9e2",  9, 9, 1'b1, 1'b1, 208, -1);
        run_frame("f3clamp", 3, 5, 1'b0, 1'b0, 112, 40);
        run_frame("f12clamp", 12, 9, 1'b0, 1'b0, 176, -1);

        // Abort on the 50th tick of an 8N1 frame.
        do_start("abort", 8, 1'b0, 1'b0);
        tick_i = 1'b1;
        repeat (49) step();
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        tick_i  = 1'b0;
        check_idle("abort");
        idle_ticks("abort_idle", 20);
        run_frame("post_abort", 8, 8, 1'b0, 1'b0, 160, -1);

        // Start and abort together: abort wins.
        cfg_data_bits_i = 4'd8;
        start_i = 1'b1;
        abort_i = 1'b1;
        tick_i  = 1'b1;
        step();
        start_i = 1'b0;
        abort_i = 1'b0;
        tick_i  = 1'b0;
        check_idle("start_abort");
        idle_ticks("start_abort_idle", 20);

        // One-cycle reset in the middle of a frame.
        do_start("rst_mid", 9, 1'b1, 1'b1);
        tick_i = 1'b1;
        repeat (30) step();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        tick_i = 1'b0;
        check_idle("rst_mid");
        idle_ticks("rst_idle", 20);
        run_frame("post_rst", 8, 8, 1'b0, 1'b0, 160, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
